pc_ctrl: RTL and testbench
==========================

# pc_ctrl

Program-counter control stage that sits directly downstream of the branch-condition evaluator. It holds the architectural PC and computes sequential, branch, jump and register-jump targets. It applies the evaluator's taken decision to redirect fetch, with an optional MIPS delay slot. It also supplies `pc`/`pc_plus4` to instruction fetch and to the target adder.

## Interface
Parameters:
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded on reset
- `CNT_W`, 16, width of redirect counter

Ports:
- `clk` input 1: clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `stall` input 1: hold all state this cycle
- `is_branch` input 1: instruction at `pc` is a conditional branch (opcode 000001/0001xx)
- `taken` input 1: branch condition result from evaluator; meaningful only with `is_branch`
- `is_jump` input 1: instruction at `pc` is j/jal
- `is_jr` input 1: instruction at `pc` is jr/jalr
- `imm16` input 16: Inst[15:0]
- `target26` input 26: Inst[25:0]
- `jr_addr` input 32: rs register value
- `pc` output 32: current fetch address
- `pc_plus4` output 32: `pc + 4` (combinational)
- `inst_valid` output 1: instruction at `pc` is to be executed
- `flush` output 1: instruction at `pc` must be squashed
- `addr_err` output 1: one-cycle pulse, misaligned jr target
- `redirect_cnt` output `CNT_W`: count of accepted redirects

## Operation
- States: BOOT, SEQ, SLOT.
- Reset (async, any time, including mid-SLOT) sets the following. All pending target state is discarded.
  - `pc` = RESET_VECTOR, state BOOT
  - `inst_valid` = 0, `flush` = 0, `addr_err` = 0
  - `redirect_cnt` = 0
- BOOT: the first unstalled edge moves to SEQ. `pc` is unchanged and `inst_valid` goes to 1.
- Redirect request in SEQ uses priority `is_jr` > `is_jump` > (`is_branch` & `taken`). The target is selected as follows:
  - jr: `{jr_addr[31:2],2'b00}`. If `jr_addr[1:0]` != 0, pulse `addr_err` for one cycle and still redirect.
  - jump: `{pc_plus4[31:28], target26, 2'b00}`.
  - branch: `pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}`, modulo 2^32 (wraps silently).
- No redirect in SEQ: `pc <= pc_plus4`. 0xFFFF_FFFC wraps to 0x0000_0000.
- An accepted redirect increments `redirect_cnt`, which wraps at 2^CNT_W.
- Redirect requests while in SLOT are ignored: a branch in a delay slot is not taken and is not counted.
- `stall`=1 freezes `pc`, state, the stored target and `redirect_cnt`. Decision inputs are ignored. `addr_err` is 0 during a stall. `flush` holds its value.

## Timing
- All outputs except `pc_plus4` are registered.
- With `DELAY_SLOT_EN`, an accepted redirect takes 2 cycles:
  - cycle N, decision: next `pc` = `pc_plus4` (slot), target latched, state SLOT
  - cycle N+1, unstalled: `pc` = target, state SEQ
  - `flush` stays 0.
- Without `DELAY_SLOT_EN`, an accepted redirect takes 1 cycle:
  - cycle N, decision: next `pc` = target, state stays SEQ
  - `flush` = 1 at cycle N+1 only, so the instruction at the new `pc` is valid and `flush` is 1 for exactly the first post-redirect cycle when that cycle is unstalled.
  - With this macro off, redirects are accepted in consecutive cycles.
- `addr_err` asserts in the cycle after the jr decision edge.

## Configuration
- `PC_DELAY_SLOT_EN` defined:
  - SLOT state is present.
  - Redirects take effect after one delay-slot instruction.
  - `flush` is tied 0.
- `PC_DELAY_SLOT_EN` undefined:
  - SLOT state and the target latch are removed.
  - Redirect is immediate and `flush` pulses as above.

## Structure
- Shared package `cpu_pkg` holds:
  - `pc_state_t` enum (BOOT, SEQ, SLOT)
  - the default RESET_VECTOR
  - the branch/jump opcode constants used by decode and the evaluator
- One sub-module, `branch_target_calc`: combinational sign-extend/shift/add for branch target and jump concatenation.

## Test plan
- Reset, release, 3 unstalled cycles → `pc` sequence 0x0, 0x0 (BOOT), 0x4, 0x8; `inst_valid` rises after BOOT.
- With delay slot, at `pc`=0x100, `is_branch`=1, `taken`=1, `imm16`=16'hFFFE → `pc` 0x104, then 0x0FC; `redirect_cnt`=1.
- Same branch with `taken`=0 → `pc` 0x104, 0x108; counter unchanged.
- `is_jump`, `is_branch` and `taken` all 1 at `pc`=0x4000_0010, `target26`=26'h0000040 → jump wins; target 0x4000_0100.
- `is_jr` with `jr_addr`=0x1003 → target 0x1000, `addr_err` single pulse; `stall` held 3 cycles mid-SLOT → `pc` frozen, then resumes to target.
- Without macro, branch taken at 0x20 → next `pc` = target, `flush`=1 for one cycle; `rst_n` low mid-redirect → `pc`=RESET_VECTOR immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC controller state encoding, default reset vector,
// and the branch/jump opcodes used by decode and the branch evaluator.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    SEQ  = 2'd1,
    SLOT = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Conditional branches: REGIMM (bltz/bgez...) plus the 0001xx group
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational target generation: PC-relative branch target and the
// region-preserving j/jal concatenation, both relative to pc+4.
module branch_target_calc (
  input  logic [31:0] pc_plus4,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  output logic [31:0] branch_target,
  output logic [31:0] jump_target
);

  logic signed [31:0] offset;

  // Word offset: sign-extend then scale by 4; the add wraps modulo 2^32
  assign offset        = {{14{imm16[15]}}, imm16, 2'b00};
  assign branch_target = pc_plus4 + $unsigned(offset);
  assign jump_target   = {pc_plus4[31:28], target26, 2'b00};

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter control stage: holds the PC and applies redirects.
// Build option PC_DELAY_SLOT_EN: redirects land after one delay-slot instruction.
module pc_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             is_branch,
  input  logic             taken,
  input  logic             is_jump,
  input  logic             is_jr,
  input  logic [15:0]      imm16,
  input  logic [25:0]      target26,
  input  logic [31:0]      jr_addr,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             inst_valid,
  output logic             flush,
  output logic             addr_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [1:0] S_BOOT = BOOT;
  localparam logic [1:0] S_SEQ  = SEQ;
`ifdef PC_DELAY_SLOT_EN
  localparam logic [1:0] S_SLOT = SLOT;
`endif

  logic [1:0]  state;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;
  logic        redirect_req;
  logic        jr_misalign;

  assign pc_plus4 = pc + 32'd4;

  branch_target_calc u_target (
    .pc_plus4      (pc_plus4),
    .imm16         (imm16),
    .target26      (target26),
    .branch_target (branch_target),
    .jump_target   (jump_target)
  );

  // Priority jr > jump > taken branch
  assign redirect_req    = is_jr | is_jump | (is_branch & taken);
  assign jr_misalign     = is_jr & (|jr_addr[1:0]);
  assign redirect_target = is_jr   ? {jr_addr[31:2], 2'b00} :
                           is_jump ? jump_target : branch_target;

`ifdef PC_DELAY_SLOT_EN
  logic [31:0] slot_target;

  assign flush = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_VECTOR;
      state        <= S_BOOT;
      inst_valid   <= 1'b0;
      addr_err     <= 1'b0;
      redirect_cnt <= '0;
`ifdef PC_DELAY_SLOT_EN
      slot_target  <= '0;
`endif
    end else if (stall) begin
      addr_err <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      case (state)
        S_BOOT: begin
          state      <= S_SEQ;
          inst_valid <= 1'b1;
        end
`ifdef PC_DELAY_SLOT_EN
        S_SLOT: begin
          pc    <= slot_target;
          state <= S_SEQ;
        end
`endif
        default: begin
          if (redirect_req) begin
            redirect_cnt <= redirect_cnt + CNT_W'(1);
            addr_err     <= jr_misalign;
`ifdef PC_DELAY_SLOT_EN
            pc           <= pc_plus4;
            slot_target  <= redirect_target;
            state        <= S_SLOT;
`else
            pc           <= redirect_target;
`endif
          end else begin
            pc <= pc_plus4;
          end
        end
      endcase
    end
  end

`ifndef PC_DELAY_SLOT_EN
  // Squash marker for the first instruction after an immediate redirect; holds through stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush <= 1'b0;
    end else if (!stall) begin
      flush <= (state == S_SEQ) && redirect_req;
    end
  end
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: randomized and directed stimulus against a
// behavioural PC model; expected outputs are queued and checked by a monitor.
module tb_pc_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int          CW = 4;
`ifdef PC_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic          is_branch;
  logic          taken;
  logic          is_jump;
  logic          is_jr;
  logic [15:0]   imm16;
  logic [25:0]   target26;
  logic [31:0]   jr_addr;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic          inst_valid;
  logic          flush;
  logic          addr_err;
  logic [CW-1:0] redirect_cnt;

  pc_ctrl #(.RESET_VECTOR(RV), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .is_branch    (is_branch),
    .taken        (taken),
    .is_jump      (is_jump),
    .is_jr        (is_jr),
    .imm16        (imm16),
    .target26     (target26),
    .jr_addr      (jr_addr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .inst_valid   (inst_valid),
    .flush        (flush),
    .addr_err     (addr_err),
    .redirect_cnt (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   pc;
    logic          iv;
    logic          fl;
    logic          ae;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   tests = 0;
  int   fails = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_tgt;
  bit          m_boot, m_slot, m_iv, m_fl, m_ae;
  int          m_cnt;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pc = RV; m_tgt = 32'h0; m_boot = 1; m_slot = 0;
    m_iv = 0; m_fl = 0; m_ae = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(bit s, bit br, bit tk, bit jm, bit jr,
                                     logic [15:0] imm, logic [25:0] t, logic [31:0] ja);
    logic [31:0] p4, tgt;
    int off;
    m_ae = 0;
    if (s) return;
    if (m_boot) begin
      m_boot = 0; m_iv = 1; m_fl = 0;
    end else if (m_slot) begin
      m_pc = m_tgt; m_slot = 0; m_fl = 0;
    end else begin
      p4 = m_pc + 32'd4;
      if (jr || jm || (br && tk)) begin
        off = $signed(imm);
        if (jr)      tgt = ja & 32'hFFFF_FFFC;
        else if (jm) tgt = (p4 & 32'hF000_0000) | (32'(t) * 4);
        else         tgt = p4 + 32'(off * 4);
        m_ae  = jr && (ja % 4 != 0);
        m_cnt = (m_cnt + 1) % (1 << CW);
        if (DS) begin
          m_pc = p4; m_tgt = tgt; m_slot = 1; m_fl = 0;
        end else begin
          m_pc = tgt; m_fl = 1;
        end
      end else begin
        m_pc = p4; m_fl = 0;
      end
    end
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.pc = m_pc; e.iv = m_iv; e.fl = m_fl; e.ae = m_ae; e.cnt = m_cnt[CW-1:0];
    return e;
  endfunction

  task automatic step(bit s, bit br, bit tk, bit jm, bit jr,
                      logic [15:0] imm, logic [25:0] t, logic [31:0] ja);
    @(negedge clk);
    rst_n = 1'b1; stall = s; is_branch = br; taken = tk; is_jump = jm; is_jr = jr;
    imm16 = imm; target26 = t; jr_addr = ja;
    model_step(s, br, tk, jm, jr, imm, t, ja);
    q.push_back(snap());
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
  endtask

  // Land the decision point at addr (through the slot when delay slots are on)
  task automatic goto(logic [31:0] addr);
    step(0, 0, 0, 0, 1, 16'h0, 26'h0, addr);
    if (DS) idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_pc", pc, RV);
    chk("async_reset_cnt", 32'(redirect_cnt), 32'h0);
    chk("async_reset_valid", 32'(inst_valid), 32'h0);
    q.push_back(snap());
  endtask

  // Monitor: outputs are presented every cycle; compare one entry per edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        me = q.pop_front();
        chk("pc", pc, me.pc);
        chk("pc_plus4", pc_plus4, me.pc + 32'd4);
        chk("inst_valid", 32'(inst_valid), 32'(me.iv));
        chk("flush", 32'(flush), 32'(me.fl));
        chk("addr_err", 32'(addr_err), 32'(me.ae));
        chk("redirect_cnt", 32'(redirect_cnt), 32'(me.cnt));
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall = 0; is_branch = 0; taken = 0; is_jump = 0; is_jr = 0;
    imm16 = '0; target26 = '0; jr_addr = '0;
    model_reset();

    do_reset();
    repeat (3) idle();

    // Misaligned jr with a stall held across the following cycles
    step(0, 0, 0, 0, 1, 16'h0, 26'h0, 32'h0000_1003);
    repeat (3) step(1, 1, 1, 1, 1, 16'h1234, 26'h3, 32'h5);
    repeat (2) idle();

    // Backward branch taken / not taken at 0x100
    goto(32'h0000_0100);
    step(0, 1, 1, 0, 0, 16'hFFFE, 26'h0, 32'h0);
    repeat (2) idle();
    goto(32'h0000_0100);
    step(0, 1, 0, 0, 0, 16'hFFFE, 26'h0, 32'h0);
    repeat (2) idle();

    // Jump outranks a taken branch
    goto(32'h4000_0010);
    step(0, 1, 1, 1, 0, 16'h0040, 26'h0000040, 32'h0);
    repeat (2) idle();

    // Sequential wrap at the top of the address space, and a wrapping branch
    goto(32'hFFFF_FFFC);
    repeat (2) idle();
    goto(32'hFFFF_FFF0);
    step(0, 1, 1, 0, 0, 16'h0010, 26'h0, 32'h0);
    repeat (2) idle();

    // Back-to-back redirects and a stall right after a redirect
    repeat (4) step(0, 1, 1, 0, 0, 16'h0004, 26'h0, 32'h0);
    step(0, 0, 0, 1, 0, 16'h0, 26'h0000123, 32'h0);
    repeat (2) step(1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    repeat (2) idle();

    // Reset while a redirect is in flight
    goto(32'h0000_0020);
    step(0, 1, 1, 0, 0, 16'h0008, 26'h0, 32'h0);
    do_reset();
    repeat (3) idle();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 35,
             $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 10,
             $urandom_range(0, 99) < 10, 16'($urandom), 26'($urandom), $urandom);
      end
    end

    repeat (2) @(negedge clk);
    chk("queue_drain", q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
